hazard_scoreboard: RTL

Parametrised register-hazard unit for the decode stage: generalises per-operand forwarding selection to any number of read ports and forwarding stages. It adds a per-register pending-write scoreboard, so producers still in flight outside the forwarding network cause a stall rather than a stale read. It sits between decode and issue, driving operand-mux selects and the decode stall / issue handshake.

---
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard unit: forwarding-select per read port plus a per-register pending-write scoreboard.
// Latency: fwd_sel/stall/issue_ready are combinational; the scoreboard updates on the rising edge.
// Backpressure: issue_ready drops on an operand hazard or when the destination's pending counter is saturated.
// Optional stall-cycle counter built only when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_READ = 2,
    parameter int NUM_FWD  = 3,
    parameter int REG_AW   = 5,
    parameter int PEND_W   = 2,
    parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       issue_we,
    input  logic [REG_AW-1:0]          issue_dest,
    input  logic [NUM_READ*REG_AW-1:0] rd_addr,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD-1:0]         fwd_finish,
    input  logic [NUM_FWD*REG_AW-1:0]  fwd_dest,
    input  logic                       retire_valid,
    input  logic [REG_AW-1:0]          retire_dest,
    input  logic                       flush,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]                stall_cnt,
`endif
    output logic [NUM_READ*SEL_W-1:0]  fwd_sel,
    output logic                       stall
);

    localparam int NUM_REG = 2 ** REG_AW;

    logic [NUM_REG-1:0][PEND_W-1:0] pend;

    logic                issue_inc;
    logic                retire_dec;
    logic                same_reg;
    logic                sat;
    logic [NUM_READ-1:0] port_haz;

    logic [REG_AW-1:0]   cur_addr;
    logic                hit;
    logic                hit_fin;
    logic [SEL_W-1:0]    hit_sel;

    // Stages are scanned oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_sel  = '0;
        port_haz = '0;
        cur_addr = '0;
        hit      = 1'b0;
        hit_fin  = 1'b0;
        hit_sel  = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            cur_addr = rd_addr[i*REG_AW +: REG_AW];
            hit      = 1'b0;
            hit_fin  = 1'b0;
            hit_sel  = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (fwd_dest[k*REG_AW +: REG_AW] == cur_addr)) begin
                    hit     = 1'b1;
                    hit_fin = fwd_finish[k];
                    hit_sel = SEL_W'(k + 1);
                end
            end
            if (cur_addr != '0) begin
                if (hit) begin
                    if (hit_fin) begin
                        fwd_sel[i*SEL_W +: SEL_W] = hit_sel;
                    end else begin
                        port_haz[i] = 1'b1;
                    end
                end else if (pend[cur_addr] != '0) begin
                    port_haz[i] = 1'b1;
                end
            end
        end
    end

    assign stall       = issue_valid && (|port_haz);
    assign retire_dec  = retire_valid && (retire_dest != '0) && (pend[retire_dest] != '0);
    assign sat         = issue_we && (issue_dest != '0) && (pend[issue_dest] == '1) &&
                         !(retire_dec && (retire_dest == issue_dest));
    assign issue_ready = !stall && !sat;
    assign issue_inc   = issue_valid && issue_ready && issue_we && (issue_dest != '0);
    assign same_reg    = issue_inc && retire_dec && (issue_dest == retire_dest);

    // Register 0 is never addressed by an event, so its counter stays at the reset value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else if (!same_reg) begin
            if (issue_inc) begin
                pend[issue_dest] <= pend[issue_dest] + 1'b1;
            end
            if (retire_dec) begin
                pend[retire_dest] <= pend[retire_dest] - 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
